precal_scheduler: RTL and testbench

- Sequences one shared 4-term fixed-point dot-product unit to build the MMSE pre-calculation operands: A = H^H·H + snr·I and b = H^H·r.
- Replaces the fully-parallel 16+4 dot-product combinational pre-calc with a time-multiplexed job issuer, one element per job.
- Sits between channel estimation (input handshake) and the linear solver (output handshake).

---
 rtl/precal_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_precal_scheduler.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/precal_scheduler.sv
// precal_scheduler: drives one shared 4-term dot-product unit to build A = H^H*H + snr*I and b = H^H*r.
// Build option PRECAL_SYMMETRY_EN: 14-job upper-triangle schedule with mirroring (default: 20 jobs, no mirroring).
module precal_scheduler #(
  parameter int DATA_W             = 32,
  parameter int DP_MAX_OUTSTANDING = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [0:3][0:3][DATA_W-1:0]   H_matrix,
  input  logic [0:3][DATA_W-1:0]        signal_receive,
  input  logic [DATA_W-1:0]             snr,
  output logic                          dp_valid,
  input  logic                          dp_ready,
  output logic [0:3][DATA_W-1:0]        dp_x,
  output logic [0:3][DATA_W-1:0]        dp_y,
  input  logic                          dp_rsp_valid,
  input  logic [DATA_W-1:0]             dp_rsp_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [0:3][0:3][DATA_W-1:0]   matrix_A,
  output logic [0:3][DATA_W-1:0]        vector_b,
  output logic                          busy
);

`ifdef PRECAL_SYMMETRY_EN
  localparam int JOBS = 14;
`else
  localparam int JOBS = 20;
`endif
  localparam int CW = 5;
  localparam int OW = 4;
  localparam logic [CW-1:0] LAST_JOB = CW'(JOBS - 1);
  localparam logic [OW-1:0] MAX_OUT  = OW'(DP_MAX_OUTSTANDING);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  typedef struct packed {
    logic       is_b;
    logic [1:0] i;
    logic [1:0] j;
  } job_t;

  typedef logic [0:3][DATA_W-1:0]      vec_t;
  typedef logic [0:3][0:3][DATA_W-1:0] mat_t;

  // Job index -> element; issue side and response side share this table.
  function automatic job_t job_decode(input logic [CW-1:0] k);
    job_t       jb;
    logic [3:0] ij;
    jb = '0;
    ij = '0;
`ifdef PRECAL_SYMMETRY_EN
    if (k < 5'd10) begin
      case (k)
        5'd0:    ij = 4'h0;
        5'd1:    ij = 4'h1;
        5'd2:    ij = 4'h2;
        5'd3:    ij = 4'h3;
        5'd4:    ij = 4'h5;
        5'd5:    ij = 4'h6;
        5'd6:    ij = 4'h7;
        5'd7:    ij = 4'hA;
        5'd8:    ij = 4'hB;
        default: ij = 4'hF;
      endcase
      jb.is_b = 1'b0;
      jb.i    = ij[3:2];
      jb.j    = ij[1:0];
    end else begin
      jb.is_b = 1'b1;
      jb.i    = k[1:0] + 2'd2;
    end
`else
    if (k < 5'd16) begin
      jb.is_b = 1'b0;
      jb.i    = k[3:2];
      jb.j    = k[1:0];
    end else begin
      jb.is_b = 1'b1;
      jb.i    = k[1:0];
    end
`endif
    return jb;
  endfunction

  function automatic vec_t h_col(input mat_t h, input logic [1:0] c);
    vec_t v;
    for (int r = 0; r < 4; r++) v[r] = h[r][c];
    return v;
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     k_q, k_d, m_q, m_d;
  logic [OW-1:0]     outst_q, outst_d;
  mat_t              h_q, h_d, a_q, a_d;
  vec_t              r_q, r_d, b_q, b_d;
  logic [DATA_W-1:0] snr_q, snr_d;
  logic              dp_valid_q, dp_valid_d;
  vec_t              dp_x_q, dp_x_d, dp_y_q, dp_y_d;
  logic              issue_fire, rsp_take;
  job_t              job_iss, job_rsp;

  assign issue_fire = dp_valid_q && dp_ready;
  // Responses only count while a frame is in flight and something is outstanding.
  assign rsp_take   = dp_rsp_valid && (outst_q != '0) &&
                      ((state_q == S_ISSUE) || (state_q == S_DRAIN));
  assign outst_d    = outst_q + OW'(issue_fire) - OW'(rsp_take);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_ISSUE;
      S_ISSUE: if (issue_fire && (k_q == LAST_JOB)) state_d = S_DRAIN;
      S_DRAIN: if (outst_d == '0) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q != S_IDLE);
  end

  always_comb begin
    k_d   = (state_q == S_IDLE) ? '0 : k_q + CW'(issue_fire);
    m_d   = (state_q == S_IDLE) ? '0 : m_q + CW'(rsp_take);
    h_d   = h_q;
    r_d   = r_q;
    snr_d = snr_q;
    if ((state_q == S_IDLE) && in_valid) begin
      h_d   = H_matrix;
      r_d   = signal_receive;
      snr_d = snr;
    end

    // Request line is registered: a job is presented the cycle after ISSUE is entered.
    dp_valid_d = (state_q == S_ISSUE) && (state_d == S_ISSUE) && (outst_d < MAX_OUT);
    job_iss    = job_decode(k_d);
    dp_x_d     = dp_x_q;
    dp_y_d     = dp_y_q;
    if (dp_valid_d) begin
      dp_x_d = h_col(h_q, job_iss.i);
      dp_y_d = job_iss.is_b ? r_q : h_col(h_q, job_iss.j);
    end

    a_d     = a_q;
    b_d     = b_q;
    job_rsp = job_decode(m_q);
    if (rsp_take) begin
      if (job_rsp.is_b) begin
        b_d[job_rsp.i] = dp_rsp_data;
      end else if (job_rsp.i == job_rsp.j) begin
        a_d[job_rsp.i][job_rsp.i] = dp_rsp_data + snr_q;
      end else begin
        a_d[job_rsp.i][job_rsp.j] = dp_rsp_data;
`ifdef PRECAL_SYMMETRY_EN
        a_d[job_rsp.j][job_rsp.i] = dp_rsp_data;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q        <= '0;
      m_q        <= '0;
      outst_q    <= '0;
      h_q        <= '0;
      r_q        <= '0;
      snr_q      <= '0;
      dp_valid_q <= 1'b0;
      dp_x_q     <= '0;
      dp_y_q     <= '0;
      a_q        <= '0;
      b_q        <= '0;
    end else begin
      k_q        <= k_d;
      m_q        <= m_d;
      outst_q    <= outst_d;
      h_q        <= h_d;
      r_q        <= r_d;
      snr_q      <= snr_d;
      dp_valid_q <= dp_valid_d;
      dp_x_q     <= dp_x_d;
      dp_y_q     <= dp_y_d;
      a_q        <= a_d;
      b_q        <= b_d;
    end
  end

  assign dp_valid = dp_valid_q;
  assign dp_x     = dp_x_q;
  assign dp_y     = dp_y_q;
  assign matrix_A = a_q;
  assign vector_b = b_q;

endmodule

// File: tb/tb_precal_scheduler.sv
// Testbench for precal_scheduler: queue-based dot-product unit model plus an arithmetic golden model of A and b.
module tb_precal_scheduler;
  localparam int DW   = 32;
  localparam int MAXO = 4;
`ifdef PRECAL_SYMMETRY_EN
  localparam int JOBS = 14;
`else
  localparam int JOBS = 20;
`endif

  typedef logic [0:3][0:3][DW-1:0] mat_t;
  typedef logic [0:3][DW-1:0]      vec4_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  mat_t          H_matrix;
  vec4_t         signal_receive;
  logic [DW-1:0] snr;
  logic          dp_valid, dp_ready;
  vec4_t         dp_x, dp_y;
  logic          dp_rsp_valid;
  logic [DW-1:0] dp_rsp_data;
  logic          out_valid, out_ready;
  mat_t          matrix_A;
  vec4_t         vector_b;
  logic          busy;

  precal_scheduler #(.DATA_W(DW), .DP_MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .H_matrix(H_matrix), .signal_receive(signal_receive), .snr(snr),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_x(dp_x), .dp_y(dp_y),
    .dp_rsp_valid(dp_rsp_valid), .dp_rsp_data(dp_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .matrix_A(matrix_A), .vector_b(vector_b), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [DW-1:0] dot(input vec4_t x, input vec4_t y);
    logic [DW-1:0] s;
    s = '0;
    for (int k = 0; k < 4; k++) s = s + x[k] * y[k];
    return s;
  endfunction

  // A = H^T H + snr*I, b = H^T r, mod 2^32; ovr forces the raw A(2,2) product to all ones.
  function automatic void golden(input mat_t h, input vec4_t r, input logic [DW-1:0] s,
                                 input bit ovr, output mat_t a, output vec4_t b);
    logic [DW-1:0] acc;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc = acc + h[k][i] * h[k][j];
        if (i == j) begin
          if (ovr && i == 2) acc = 32'hFFFF_FFFF;
          acc = acc + s;
        end
        a[i][j] = acc;
      end
      acc = '0;
      for (int k = 0; k < 4; k++) acc = acc + h[k][i] * r[k];
      b[i] = acc;
    end
  endfunction

  // Dot-product unit model: in-order queue with configurable latency and ready pattern.
  typedef struct {
    logic [DW-1:0] val;
    int            t;
  } rsp_t;
  rsp_t  q[$];
  int    lat = 1, rdy_mode = 0, mcyc = 0;
  bit    ovr_en = 0;
  vec4_t ovr_col;
  int    issues = 0, stale = 0, overissue = 0, holdbad = 0;

  initial begin : dp_unit
    bit    fire, took, prev_stall;
    vec4_t xs, ys, px, py;
    rsp_t  e;
    dp_ready = 1'b1; dp_rsp_valid = 1'b0; dp_rsp_data = '0;
    prev_stall = 0; px = '0; py = '0;
    forever begin
      @(negedge clk);
      fire = dp_valid && dp_ready;
      took = dp_rsp_valid;
      xs = dp_x; ys = dp_y;
      if (dp_valid && q.size() >= MAXO) overissue++;
      if (prev_stall && !reset && (!dp_valid || dp_x != px || dp_y != py)) holdbad++;
      prev_stall = dp_valid && !dp_ready && !reset;
      px = dp_x; py = dp_y;
      if (took && !busy) stale++;
      @(posedge clk);
      #1;
      mcyc++;
      if (took && q.size() > 0) void'(q.pop_front());
      if (fire) begin
        e.val = (ovr_en && xs == ovr_col && ys == ovr_col) ? 32'hFFFF_FFFF : dot(xs, ys);
        e.t   = mcyc + lat - 1;
        q.push_back(e);
        issues++;
      end
      dp_rsp_valid = (q.size() > 0) && (q[0].t <= mcyc);
      dp_rsp_data  = (q.size() > 0) ? q[0].val : '0;
      case (rdy_mode)
        0:       dp_ready = 1'b1;
        1:       dp_ready = ~dp_ready;
        default: dp_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  typedef struct {
    int            hkind;
    logic [DW-1:0] snr;
    int            lat;
    int            rdy;
    bit            ovr;
    int            hold;
    bit            spot_en;
    int            si;
    int            sj;
    logic [DW-1:0] spot;
    bit            chk_lat;
  } vec_t;

  task automatic set_frame(input int hkind, input logic [DW-1:0] s);
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < 4; c++) begin
        case (hkind)
          0:       H_matrix[k][c] = (k == c) ? 32'd1 : 32'd0;
          1:       H_matrix[k][c] = 32'(k + c);
          default: H_matrix[k][c] = $urandom;
        endcase
      end
      signal_receive[k] = (hkind < 2) ? 32'(k + 1) : $urandom;
      ovr_col[k] = H_matrix[k][2];
    end
    snr = s;
  endtask

  task automatic wait_q_empty();
    int n;
    n = 0;
    while (q.size() > 0 && n < 200) begin step(); n++; end
    check("dp_queue_drained", 64'(q.size()), 64'(0));
  endtask

  task automatic run_frame(input vec_t v);
    mat_t  ea, snap_a;
    vec4_t eb, snap_b;
    int    n, hbad;
    bit    acc;
    wait_q_empty();
    golden(H_matrix, signal_receive, snr, v.ovr, ea, eb);
    lat = v.lat; rdy_mode = v.rdy; ovr_en = v.ovr; issues = 0;
    in_valid = 1'b1;
    acc = 0;
    for (n = 0; n < 50 && !acc; n++) begin
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    check("frame_accepted", 64'(acc), 64'(1));
    n = 0;
    while (!out_valid && n < 3000) begin step(); n++; end
    check("out_valid_seen", 64'(out_valid), 64'(1));
    if (v.chk_lat) check("latency", 64'(n), 64'(JOBS + 2));
    check("issue_count", 64'(issues), 64'(JOBS));
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++)
        check($sformatf("A[%0d][%0d]", i, j), 64'(matrix_A[i][j]), 64'(ea[i][j]));
      check($sformatf("b[%0d]", i), 64'(vector_b[i]), 64'(eb[i]));
    end
    if (v.spot_en)
      check($sformatf("spot_A[%0d][%0d]", v.si, v.sj), 64'(matrix_A[v.si][v.sj]), 64'(v.spot));
    if (v.hold > 0) begin
      snap_a = matrix_A; snap_b = vector_b; hbad = 0;
      in_valid = 1'b1;
      for (int c = 0; c < v.hold; c++) begin
        step();
        if (out_valid !== 1'b1 || matrix_A !== snap_a || vector_b !== snap_b || in_ready !== 1'b0)
          hbad++;
      end
      check("done_hold_stable", 64'(hbad), 64'(0));
    end
    out_ready = 1'b1; in_valid = 1'b0;
    step();
    out_ready = 1'b0;
    check("post_hs_in_ready", 64'(in_ready), 64'(1));
    check("post_hs_out_valid", 64'(out_valid), 64'(0));
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : main
    vec_t tbl[7];
    vec_t rv;
    int   n;
    tbl[0] = '{0, 32'd5, 1, 0, 1'b0, 0,  1'b1, 0, 0, 32'd6,  1'b1};
    tbl[1] = '{1, 32'd0, 1, 0, 1'b0, 0,  1'b1, 0, 1, 32'd20, 1'b1};
    tbl[2] = '{1, 32'd0, 6, 1, 1'b0, 0,  1'b1, 1, 0, 32'd20, 1'b0};
    tbl[3] = '{1, 32'd0, 6, 0, 1'b0, 0,  1'b1, 3, 3, 32'd86, 1'b0};
    tbl[4] = '{0, 32'd2, 1, 0, 1'b1, 0,  1'b1, 2, 2, 32'd1,  1'b0};
    tbl[5] = '{1, 32'd7, 2, 0, 1'b0, 10, 1'b1, 2, 2, 32'd61, 1'b0};
    tbl[6] = '{0, 32'd5, 1, 0, 1'b0, 0,  1'b1, 1, 3, 32'd0,  1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    set_frame(0, 32'd0);
    step(); step();
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_dp_valid", 64'(dp_valid), 64'(0));
    check("rst_A_zero", 64'(matrix_A == '0), 64'(1));
    check("rst_b_zero", 64'(vector_b == '0), 64'(1));
    check("rst_dp_xy_zero", 64'((dp_x == '0) && (dp_y == '0)), 64'(1));
    reset = 1'b0;
    step();

    for (int t = 0; t < 7; t++) begin
      set_frame(tbl[t].hkind, tbl[t].snr);
      run_frame(tbl[t]);
    end

    // Reset in the middle of ISSUE, then stale responses land while idle.
    set_frame(1, 32'd3);
    wait_q_empty();
    lat = 3; rdy_mode = 0; ovr_en = 0; issues = 0; stale = 0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    in_valid = 1'b0;
    n = 0;
    while (issues < 5 && n < 100) begin step(); n++; end
    check("pre_reset_issues", 64'(issues), 64'(5));
    reset = 1'b1;
    step();
    check("mid_rst_dp_valid", 64'(dp_valid), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    step();
    reset = 1'b0;
    n = 0;
    while (q.size() > 0 && n < 100) begin step(); n++; end
    step();
    check("stale_rsp_seen", 64'(stale >= 2), 64'(1));
    check("post_rst_A_zero", 64'(matrix_A == '0), 64'(1));
    check("post_rst_b_zero", 64'(vector_b == '0), 64'(1));
    check("post_rst_idle", 64'({busy, in_ready, out_valid, dp_valid}), 64'(4'b0100));
    set_frame(1, 32'd9);
    rv = '{1, 32'd9, 1, 0, 1'b0, 0, 1'b1, 0, 0, 32'd23, 1'b1};
    run_frame(rv);

    for (int t = 0; t < 6; t++) begin
      rv = '{2, $urandom, int'($urandom_range(1, 7)), 2, 1'b0, 0, 1'b0, 0, 0, 32'd0, 1'b0};
      set_frame(2, rv.snr);
      run_frame(rv);
    end

    check("no_overissue", 64'(overissue), 64'(0));
    check("dp_operands_held", 64'(holdbad), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
